// File: rtl/pc_call_stack_unit.sv
// Program sequencer: PC, call/data stack, single-level interrupt entry/return,
// sticky fault on stack overflow, underflow or illegal RETI.
module pc_call_stack_unit #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int DEPTH = 1024,
  parameter int RAW = 8,
  localparam int SW = $clog2(DEPTH) + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           run,
  input  logic           stall,
  input  logic [2:0]     op,
  input  logic [AW-1:0]  target,
  input  logic [DW-1:0]  push_data,
  input  logic [RAW-1:0] dst_addr,
  input  logic           irq,
  input  logic [AW-1:0]  irq_vec,
  output logic [AW-1:0]  pc,
  output logic           wr_en,
  output logic [RAW-1:0] wr_addr,
  output logic [DW-1:0]  wr_data,
  output logic [SW-1:0]  stack_size,
  output logic           in_isr,
  output logic           fault,
  output logic [1:0]     fault_code
);

  localparam int IW = SW - 1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_PUSH = 3'd4;
  localparam logic [2:0] OP_POP  = 3'd5;
  localparam logic [2:0] OP_GSA  = 3'd6;
  localparam logic [2:0] OP_RETI = 3'd7;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t state, state_n;

  logic [DW-1:0]  mem [DEPTH];
  logic [IW-1:0]  top_idx;
  logic [DW-1:0]  entry;
  logic [AW-1:0]  pc_inc;
  logic           full;
  logic           empty;
  logic [1:0]     err;

  logic [AW-1:0]  pc_n;
  logic [SW-1:0]  size_n;
  logic           isr_n;
  logic           wen_n;
  logic [RAW-1:0] wa_n;
  logic [DW-1:0]  wd_n;
  logic           fault_n;
  logic [1:0]     code_n;
  logic           push_en;
  logic [DW-1:0]  push_val;

  assign top_idx = stack_size[IW-1:0] - 1'b1;
  assign entry   = mem[top_idx];
  assign pc_inc  = pc + 1'b1;
  assign full    = (stack_size == SW'(DEPTH));
  assign empty   = (stack_size == '0);

  always_comb begin
    err = 2'd0;
    if ((op == OP_CALL || op == OP_PUSH) && full)
      err = 2'd1;
    if ((op == OP_RET || op == OP_POP || op == OP_RETI) && empty)
      err = 2'd2;
    // Illegal RETI outranks underflow
    if (op == OP_RETI && !in_isr)
      err = 2'd3;
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    size_n   = stack_size;
    isr_n    = in_isr;
    wen_n    = 1'b0;
    wa_n     = wr_addr;
    wd_n     = wr_data;
    fault_n  = fault;
    code_n   = fault_code;
    push_en  = 1'b0;
    push_val = DW'(pc_inc);
    if (state == RUN && run && !stall) begin
      if (irq && op == OP_NOP && !in_isr && !full) begin
        push_en = 1'b1;
        size_n  = stack_size + 1'b1;
        pc_n    = irq_vec;
        isr_n   = 1'b1;
      end else if (err != 2'd0) begin
        fault_n = 1'b1;
        code_n  = err;
        state_n = FAULT;
      end else begin
        unique case (op)
          OP_NOP: pc_n = pc_inc;
          OP_JMP: pc_n = target;
          OP_CALL: begin
            push_en = 1'b1;
            size_n  = stack_size + 1'b1;
            pc_n    = target;
          end
          OP_RET: begin
            size_n = stack_size - 1'b1;
            pc_n   = entry[AW-1:0];
          end
          OP_PUSH: begin
            push_en  = 1'b1;
            push_val = push_data;
            size_n   = stack_size + 1'b1;
            pc_n     = pc_inc;
          end
          OP_POP: begin
            size_n = stack_size - 1'b1;
            wen_n  = 1'b1;
            wa_n   = dst_addr;
            wd_n   = entry;
            pc_n   = pc_inc;
          end
          OP_GSA: begin
            wen_n = 1'b1;
            wa_n  = dst_addr;
            wd_n  = DW'(stack_size);
            pc_n  = pc_inc;
          end
          OP_RETI: begin
            size_n = stack_size - 1'b1;
            pc_n   = entry[AW-1:0];
            isr_n  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(negedge clock) begin
    if (push_en && !reset)
      mem[stack_size[IW-1:0]] <= push_val;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      pc         <= '0;
      stack_size <= '0;
      in_isr     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      fault      <= 1'b0;
      fault_code <= 2'd0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      stack_size <= size_n;
      in_isr     <= isr_n;
      wr_en      <= wen_n;
      wr_addr    <= wa_n;
      wr_data    <= wd_n;
      fault      <= fault_n;
      fault_code <= code_n;
    end
  end

endmodule

// File: tb/tb_pc_call_stack_unit.sv
// Scoreboard bench for pc_call_stack_unit (DEPTH=4): directed ops queue
// expected state; a monitor pops and compares after each active edge.
module tb_pc_call_stack_unit;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] JMP  = 3'd1;
  localparam logic [2:0] CALL = 3'd2;
  localparam logic [2:0] RET  = 3'd3;
  localparam logic [2:0] PUSH = 3'd4;
  localparam logic [2:0] POP  = 3'd5;
  localparam logic [2:0] GSA  = 3'd6;
  localparam logic [2:0] RETI = 3'd7;

  logic        clock;
  logic        reset;
  logic        run;
  logic        stall;
  logic [2:0]  op;
  logic [15:0] target;
  logic [31:0] push_data;
  logic [7:0]  dst_addr;
  logic        irq;
  logic [15:0] irq_vec;
  logic [15:0] pc;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  stack_size;
  logic        in_isr;
  logic        fault;
  logic [1:0]  fault_code;

  pc_call_stack_unit #(
    .AW(16), .DW(32), .DEPTH(4), .RAW(8)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .stall(stall),
    .op(op), .target(target), .push_data(push_data),
    .dst_addr(dst_addr), .irq(irq), .irq_vec(irq_vec),
    .pc(pc), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .stack_size(stack_size), .in_isr(in_isr), .fault(fault),
    .fault_code(fault_code)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  size;
    logic        isr;
    logic [1:0]  code;
    logic        wr;
    logic [7:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int stepno = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      stepno++;
      total++;
      if (pc !== e.pc || stack_size !== e.size || in_isr !== e.isr ||
          fault !== (e.code != 2'd0) || fault_code !== e.code ||
          wr_en !== e.wr ||
          (e.wr && (wr_addr !== e.wa || wr_data !== e.wd))) begin
        bad++;
        $display("FAIL step%0d got pc=%h sz=%0d isr=%b flt=%b code=%0d wr=%b wa=%h wd=%h want pc=%h sz=%0d isr=%b code=%0d wr=%b wa=%h wd=%h",
                 stepno, pc, stack_size, in_isr, fault, fault_code,
                 wr_en, wr_addr, wr_data, e.pc, e.size, e.isr, e.code,
                 e.wr, e.wa, e.wd);
      end
    end
  end

  task automatic step(
    input logic r, input logic s, input logic i,
    input logic [2:0] o, input logic [15:0] t,
    input logic [31:0] pd, input logic [7:0] d,
    input logic [15:0] epc, input logic [2:0] esz,
    input logic eisr, input logic [1:0] ecode,
    input logic ewr, input logic [7:0] ewa, input logic [31:0] ewd);
    @(posedge clock);
    #1;
    run = r;
    stall = s;
    irq = i;
    op = o;
    target = t;
    push_data = pd;
    dst_addr = d;
    q.push_back(exp_t'{epc, esz, eisr, ecode, ewr, ewa, ewd});
  endtask

  task automatic rcheck(input string name);
    total++;
    if (pc !== 16'h0 || stack_size !== 3'd0 || wr_en !== 1'b0 ||
        wr_addr !== 8'h0 || wr_data !== 32'h0 || in_isr !== 1'b0 ||
        fault !== 1'b0 || fault_code !== 2'd0) begin
      bad++;
      $display("FAIL %s got pc=%h sz=%0d wr=%b wa=%h wd=%h isr=%b flt=%b code=%0d want all zero",
               name, pc, stack_size, wr_en, wr_addr, wr_data, in_isr,
               fault, fault_code);
    end
  endtask

  task automatic reset_pulse(input string name);
    @(posedge clock);
    #2;
    run = 1'b0;
    irq = 1'b0;
    op = NOP;
    reset = 1'b1;
    #1;
    rcheck(name);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    stall = 1'b0;
    op = NOP;
    target = '0;
    push_data = '0;
    dst_addr = '0;
    irq = 1'b0;
    irq_vec = 16'h0080;
    #3;
    rcheck("por");
    @(posedge clock);
    #3;
    reset = 1'b0;

    for (int k = 1; k <= 5; k++)
      step(1, 0, 0, NOP, 0, 0, 0, 16'(k), 0, 0, 0, 0, 0, 0);

    step(1, 0, 0, JMP,  16'h0010, 0, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, CALL, 16'h0100, 0, 0, 16'h0100, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, RET,  0, 0, 0, 16'h0011, 0, 0, 0, 0, 0, 0);

    step(1, 0, 0, PUSH, 0, 32'hDEADBEEF, 0, 16'h0012, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, GSA,  0, 0, 8'd3, 16'h0013, 1, 0, 0, 1, 8'd3, 32'd1);
    step(1, 0, 0, POP,  0, 0, 8'd5, 16'h0014, 0, 0, 0, 1, 8'd5,
         32'hDEADBEEF);

    step(1, 0, 0, JMP, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, NOP, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);

    step(0, 0, 0, JMP, 16'h0050, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, JMP, 16'h0050, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, GSA, 0, 0, 8'd9, 16'h0001, 0, 0, 0, 1, 8'd9, 32'd0);
    step(0, 0, 0, GSA, 0, 0, 8'd9, 16'h0001, 0, 0, 0, 0, 0, 0);

    step(1, 0, 0, JMP,  16'h0020, 0, 0, 16'h0020, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, NOP,  0, 0, 0, 16'h0080, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, NOP,  0, 0, 0, 16'h0081, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, RETI, 0, 0, 0, 16'h0021, 0, 0, 0, 0, 0, 0);

    step(1, 0, 0, CALL, 16'h0200, 0, 0, 16'h0200, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, CALL, 16'h0300, 0, 0, 16'h0300, 2, 0, 0, 0, 0, 0);
    step(1, 0, 0, CALL, 16'h0400, 0, 0, 16'h0400, 3, 0, 0, 0, 0, 0);
    step(1, 0, 0, CALL, 16'h0500, 0, 0, 16'h0500, 4, 0, 0, 0, 0, 0);
    step(1, 0, 1, NOP,  0, 0, 0, 16'h0501, 4, 0, 0, 0, 0, 0);
    step(1, 0, 0, POP,  0, 0, 8'd7, 16'h0502, 3, 0, 0, 1, 8'd7,
         32'h0000_0401);
    step(1, 0, 0, PUSH, 0, 32'hAB, 0, 16'h0503, 4, 0, 0, 0, 0, 0);
    step(1, 0, 0, CALL, 16'h0600, 0, 0, 16'h0503, 4, 0, 1, 0, 0, 0);
    step(1, 0, 0, NOP,  0, 0, 0, 16'h0503, 4, 0, 1, 0, 0, 0);
    step(1, 0, 0, RET,  0, 0, 0, 16'h0503, 4, 0, 1, 0, 0, 0);
    step(1, 0, 0, GSA,  0, 0, 8'd2, 16'h0503, 4, 0, 1, 0, 0, 0);
    reset_pulse("rst_in_fault_ovf");

    step(1, 0, 0, RETI, 0, 0, 0, 16'h0000, 0, 0, 3, 0, 0, 0);
    step(1, 0, 0, NOP,  0, 0, 0, 16'h0000, 0, 0, 3, 0, 0, 0);
    reset_pulse("rst_in_fault_reti");

    step(1, 0, 0, POP, 0, 0, 8'd1, 16'h0000, 0, 0, 2, 0, 0, 0);
    step(1, 0, 0, NOP, 0, 0, 0, 16'h0000, 0, 0, 2, 0, 0, 0);
    reset_pulse("rst_in_fault_udf");

    repeat (3) @(posedge clock);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
